// File: rtl/mshr_rsp_pkg.sv
// Shared D-cache definitions for the miss tracker: field widths, the
// coherence message type, the per-entry state encoding and a small helper
// that identifies requests which return data.
package mshr_rsp_pkg;

   localparam int DCACHE_TAG_W        = 20;
   localparam int DCACHE_IDX_W        = 6;
   localparam int DCACHE_WORD_IN_BITS = 32;
   localparam int MSHR_TXN_NUM        = 16;
   localparam int MSHR_TXN_W          = 4;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      GET_S = 2'd1,
      GET_M = 2'd2,
      PUT_M = 2'd3
   } message_t;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      WAIT = 2'd1,
      RDY  = 2'd2
   } entry_state_t;

   // Only read-type requests come back with data and need a table entry.
   function automatic logic is_get(input message_t m);
      return (m == GET_S) || (m == GET_M);
   endfunction

endpackage

// File: rtl/mshr_rsp_prio_enc.sv
// Lowest-index priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   found : at least one request bit set
//   idx   : index of the lowest set bit (0 when none)
module mshr_rsp_prio_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Scan from the top down so the last hit written is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/mshr_rsp.sv
// Response-side miss tracker for the non-blocking D-cache.
// Acks the head issue request when memory returns a nonzero transaction ID,
// parks read requests in a table indexed by that ID, marks them ready when
// memory data returns, drains ready entries to the fill port (lowest ID
// first) and answers load-queue address probes.
//   clk, rst            : clock, synchronous active-high reset
//   iss_*               : head-of-issue-queue request; iss_ack_o pops it
//   mem_rsp_i           : nonzero = request accepted with this ID
//   mem_tag_i/mem_data_i: nonzero tag = data returning for this ID
//   fill_*              : lowest ready entry, consumed by fill_ack_i
//   lq_*                : load probe, pending (WAIT) or hit (RDY) with data
//   pending_cnt_o       : number of non-FREE entries
//   err_o               : sticky protocol error
module mshr_rsp
   import mshr_rsp_pkg::*;
#(
   parameter int TXN_NUM = 16,
   parameter int TXN_W   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           iss_en_i,
   input  logic [DCACHE_TAG_W-1:0]        iss_tag_i,
   input  logic [DCACHE_IDX_W-1:0]        iss_idx_i,
   input  logic [DCACHE_WORD_IN_BITS-1:0] iss_data_i,
   input  message_t                       iss_message_i,
   input  logic                           iss_stq_c_flag_i,
   output logic                           iss_ack_o,
   input  logic [TXN_W-1:0]               mem_rsp_i,
   input  logic [TXN_W-1:0]               mem_tag_i,
   input  logic [DCACHE_WORD_IN_BITS-1:0] mem_data_i,
   output logic                           fill_en_o,
   output logic [DCACHE_TAG_W-1:0]        fill_tag_o,
   output logic [DCACHE_IDX_W-1:0]        fill_idx_o,
   output message_t                       fill_message_o,
   output logic                           fill_stq_c_flag_o,
   output logic [DCACHE_WORD_IN_BITS-1:0] fill_data_o,
   output logic [DCACHE_WORD_IN_BITS-1:0] fill_st_data_o,
   input  logic                           fill_ack_i,
   input  logic [DCACHE_TAG_W-1:0]        lq_tag_i,
   input  logic [DCACHE_IDX_W-1:0]        lq_idx_i,
   output logic                           lq_pending_o,
   output logic                           lq_hit_o,
   output logic [DCACHE_WORD_IN_BITS-1:0] lq_hit_data_o,
   output logic [TXN_W-1:0]               pending_cnt_o,
   output logic                           err_o
);

   entry_state_t                   st_q    [TXN_NUM];
   logic [DCACHE_TAG_W-1:0]        tag_q   [TXN_NUM];
   logic [DCACHE_IDX_W-1:0]        idx_q   [TXN_NUM];
   logic [DCACHE_WORD_IN_BITS-1:0] sdata_q [TXN_NUM];
   logic [DCACHE_WORD_IN_BITS-1:0] mdata_q [TXN_NUM];
   message_t                       msg_q   [TXN_NUM];
   logic                           flag_q  [TXN_NUM];
   logic [TXN_W-1:0]               cnt_q;
   logic                           err_q;

   logic [TXN_NUM-1:0] rdy_vec;
   logic [TXN_NUM-1:0] match_vec;
   logic               fill_found;
   logic [TXN_W-1:0]   fill_sel;
   logic               probe_found;
   logic [TXN_W-1:0]   probe_sel;

   logic rec_req, rec_ok, dat_req, dat_ok, drain, err_evt;

   always_comb begin
      rdy_vec   = '0;
      match_vec = '0;
      for (int i = 0; i < TXN_NUM; i++) begin
         rdy_vec[i]   = (st_q[i] == RDY);
         match_vec[i] = (st_q[i] != FREE) && (tag_q[i] == lq_tag_i) &&
                        (idx_q[i] == lq_idx_i);
      end
   end

   mshr_rsp_prio_enc #(.N(TXN_NUM), .W(TXN_W)) u_fill_sel (
      .req   (rdy_vec),
      .found (fill_found),
      .idx   (fill_sel)
   );

   mshr_rsp_prio_enc #(.N(TXN_NUM), .W(TXN_W)) u_probe_sel (
      .req   (match_vec),
      .found (probe_found),
      .idx   (probe_sel)
   );

   assign iss_ack_o = iss_en_i && (mem_rsp_i != '0);

   // Entry 0 is never written, so its all-zero fields are what the fill
   // port shows while nothing is ready.
   assign fill_en_o         = fill_found;
   assign fill_tag_o        = tag_q[fill_sel];
   assign fill_idx_o        = idx_q[fill_sel];
   assign fill_message_o    = msg_q[fill_sel];
   assign fill_stq_c_flag_o = flag_q[fill_sel];
   assign fill_data_o       = mdata_q[fill_sel];
   assign fill_st_data_o    = sdata_q[fill_sel];

   // The lowest matching live entry decides between pending and hit.
   assign lq_pending_o  = probe_found && (st_q[probe_sel] == WAIT);
   assign lq_hit_o      = probe_found && (st_q[probe_sel] == RDY);
   assign lq_hit_data_o = lq_hit_o ? mdata_q[probe_sel] : '0;

   assign pending_cnt_o = cnt_q;
   assign err_o         = err_q;

   // All decisions use the pre-edge state; legal events always target
   // distinct entries, since each one requires a different current state.
   assign rec_req = iss_ack_o && is_get(iss_message_i);
   assign rec_ok  = rec_req && (st_q[mem_rsp_i] == FREE);
   assign dat_req = (mem_tag_i != '0);
   assign dat_ok  = dat_req && (st_q[mem_tag_i] == WAIT) &&
                    !(rec_req && (mem_rsp_i == mem_tag_i));
   assign drain   = fill_ack_i && fill_en_o;
   assign err_evt = (rec_req && !rec_ok) || (dat_req && !dat_ok) ||
                    (fill_ack_i && !fill_en_o);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TXN_NUM; i++) begin
            st_q[i]    <= FREE;
            tag_q[i]   <= '0;
            idx_q[i]   <= '0;
            sdata_q[i] <= '0;
            mdata_q[i] <= '0;
            msg_q[i]   <= NONE;
            flag_q[i]  <= 1'b0;
         end
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (rec_ok) begin
            st_q[mem_rsp_i]    <= WAIT;
            tag_q[mem_rsp_i]   <= iss_tag_i;
            idx_q[mem_rsp_i]   <= iss_idx_i;
            sdata_q[mem_rsp_i] <= iss_data_i;
            msg_q[mem_rsp_i]   <= iss_message_i;
            flag_q[mem_rsp_i]  <= iss_stq_c_flag_i;
         end
         if (dat_ok) begin
            st_q[mem_tag_i]    <= RDY;
            mdata_q[mem_tag_i] <= mem_data_i;
         end
         if (drain) begin
            st_q[fill_sel]    <= FREE;
            tag_q[fill_sel]   <= '0;
            idx_q[fill_sel]   <= '0;
            sdata_q[fill_sel] <= '0;
            mdata_q[fill_sel] <= '0;
            msg_q[fill_sel]   <= NONE;
            flag_q[fill_sel]  <= 1'b0;
         end
         // Data return moves WAIT->RDY and leaves the live count unchanged.
         cnt_q <= cnt_q + TXN_W'(rec_ok) - TXN_W'(drain);
         if (err_evt) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mshr_rsp.sv
module tb_mshr_rsp;
   import mshr_rsp_pkg::*;

   logic        clk;
   logic        rst;
   logic        iss_en;
   logic [19:0] iss_tag;
   logic [5:0]  iss_idx;
   logic [31:0] iss_data;
   message_t    iss_msg;
   logic        iss_flag;
   logic        iss_ack;
   logic [3:0]  mem_rsp;
   logic [3:0]  mem_tag;
   logic [31:0] mem_data;
   logic        fill_en;
   logic [19:0] fill_tag;
   logic [5:0]  fill_idx;
   message_t    fill_msg;
   logic        fill_flag;
   logic [31:0] fill_data;
   logic [31:0] fill_st_data;
   logic        fill_ack;
   logic [19:0] lq_tag;
   logic [5:0]  lq_idx;
   logic        lq_pending;
   logic        lq_hit;
   logic [31:0] lq_hit_data;
   logic [3:0]  pending_cnt;
   logic        err;

   mshr_rsp #(.TXN_NUM(16), .TXN_W(4)) dut (
      .clk(clk), .rst(rst),
      .iss_en_i(iss_en), .iss_tag_i(iss_tag), .iss_idx_i(iss_idx),
      .iss_data_i(iss_data), .iss_message_i(iss_msg),
      .iss_stq_c_flag_i(iss_flag), .iss_ack_o(iss_ack),
      .mem_rsp_i(mem_rsp), .mem_tag_i(mem_tag), .mem_data_i(mem_data),
      .fill_en_o(fill_en), .fill_tag_o(fill_tag), .fill_idx_o(fill_idx),
      .fill_message_o(fill_msg), .fill_stq_c_flag_o(fill_flag),
      .fill_data_o(fill_data), .fill_st_data_o(fill_st_data),
      .fill_ack_i(fill_ack), .lq_tag_i(lq_tag), .lq_idx_i(lq_idx),
      .lq_pending_o(lq_pending), .lq_hit_o(lq_hit),
      .lq_hit_data_o(lq_hit_data), .pending_cnt_o(pending_cnt), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference table: 0 = free, 1 = waiting for data, 2 = ready to fill.
   int          m_st  [16];
   logic [19:0] m_tag [16];
   logic [5:0]  m_idx [16];
   logic [31:0] m_sd  [16];
   logic [31:0] m_md  [16];
   message_t    m_msg [16];
   logic        m_flag[16];
   logic        m_err;
   bit          m_init = 0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int model_fill_sel();
      for (int i = 1; i < 16; i++) if (m_st[i] == 2) return i;
      return -1;
   endfunction

   function automatic int pick_state(input int s);
      int q[$];
      for (int i = 1; i < 16; i++) if (m_st[i] == s) q.push_back(i);
      if (q.size() == 0) return 0;
      return q[$urandom_range(0, q.size() - 1)];
   endfunction

   // Compare process: every output against the reference, every cycle.
   task automatic check_model();
      int fsel, psel, cnt;
      bit exp_pend, exp_hit;
      if (!m_init) return;
      fsel = model_fill_sel();
      psel = -1;
      cnt  = 0;
      for (int i = 1; i < 16; i++) begin
         if (m_st[i] != 0) cnt++;
         if (psel < 0 && m_st[i] != 0 && m_tag[i] == lq_tag && m_idx[i] == lq_idx) psel = i;
      end
      exp_pend = 0;
      exp_hit  = 0;
      if (psel >= 0) begin
         exp_pend = (m_st[psel] == 1);
         exp_hit  = (m_st[psel] == 2);
      end
      chk("iss_ack", iss_ack, iss_en && mem_rsp != 0);
      chk("fill_en", fill_en, fsel >= 0);
      if (fsel >= 0) begin
         chk("fill_tag", fill_tag, m_tag[fsel]);
         chk("fill_idx", fill_idx, m_idx[fsel]);
         chk("fill_msg", fill_msg, m_msg[fsel]);
         chk("fill_flag", fill_flag, m_flag[fsel]);
         chk("fill_data", fill_data, m_md[fsel]);
         chk("fill_st_data", fill_st_data, m_sd[fsel]);
      end
      chk("lq_pending", lq_pending, exp_pend);
      chk("lq_hit", lq_hit, exp_hit);
      if (exp_hit) chk("lq_hit_data", lq_hit_data, m_md[psel]);
      chk("pending_cnt", pending_cnt, cnt);
      chk("err", err, m_err);
   endtask

   task automatic model_update();
      int  fsel;
      bit  rec, rec_ok, dat, dat_ok, drain;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_st[i] = 0; m_tag[i] = 0; m_idx[i] = 0; m_sd[i] = 0;
            m_md[i] = 0; m_msg[i] = NONE; m_flag[i] = 0;
         end
         m_err  = 0;
         m_init = 1;
         return;
      end
      if (!m_init) return;
      fsel   = model_fill_sel();
      rec    = iss_en && mem_rsp != 0 && (iss_msg == GET_S || iss_msg == GET_M);
      rec_ok = rec && m_st[mem_rsp] == 0;
      dat    = mem_tag != 0;
      dat_ok = dat && m_st[mem_tag] == 1 && !(rec && mem_rsp == mem_tag);
      drain  = fill_ack && fsel >= 0;
      if ((rec && !rec_ok) || (dat && !dat_ok) || (fill_ack && fsel < 0)) m_err = 1;
      if (rec_ok) begin
         m_st[mem_rsp] = 1; m_tag[mem_rsp] = iss_tag; m_idx[mem_rsp] = iss_idx;
         m_sd[mem_rsp] = iss_data; m_msg[mem_rsp] = iss_msg; m_flag[mem_rsp] = iss_flag;
      end
      if (dat_ok) begin
         m_st[mem_tag] = 2; m_md[mem_tag] = mem_data;
      end
      if (drain) begin
         m_st[fsel] = 0; m_tag[fsel] = 0; m_idx[fsel] = 0; m_sd[fsel] = 0;
         m_md[fsel] = 0; m_msg[fsel] = NONE; m_flag[fsel] = 0;
      end
   endtask

   // Inputs are set at posedge+1; outputs are checked at posedge+3.
   task automatic cyc();
      #2;
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      iss_en = 0; iss_tag = 0; iss_idx = 0; iss_data = 0; iss_msg = NONE;
      iss_flag = 0; mem_rsp = 0; mem_tag = 0; mem_data = 0; fill_ack = 0;
   endtask

   task automatic issue(input message_t m, input logic [19:0] t, input logic [5:0] ix,
                        input logic [31:0] d, input logic [3:0] id);
      iss_en = 1; iss_msg = m; iss_tag = t; iss_idx = ix; iss_data = d;
      iss_flag = 0; mem_rsp = id;
   endtask

   task automatic do_reset();
      rst = 1; idle(); cyc(); rst = 0;
   endtask

   initial begin
      int r;
      rst = 1; idle(); lq_tag = 0; lq_idx = 0;
      cyc(); cyc();
      rst = 0;
      #1;
      chk("rst_fill_en", fill_en, 0);
      chk("rst_lq_pending", lq_pending, 0);
      chk("rst_lq_hit", lq_hit, 0);
      chk("rst_pending_cnt", pending_cnt, 0);
      chk("rst_err", err, 0);

      // GET_S tag 0x12 idx 3 at ID 5.
      lq_tag = 20'h12; lq_idx = 6'd3;
      issue(GET_S, 20'h12, 6'd3, 32'h0, 4'd5);
      #1 chk("ack_gets", iss_ack, 1);
      cyc(); idle();
      #1;
      chk("cnt_after_gets", pending_cnt, 1);
      chk("probe_pending", lq_pending, 1);
      mem_tag = 4'd5; mem_data = 32'hDEAD_BEEF;
      cyc(); idle();
      #1;
      chk("fill_en_ret", fill_en, 1);
      chk("fill_data_ret", fill_data, 32'hDEAD_BEEF);
      chk("fill_tag_ret", fill_tag, 20'h12);
      chk("probe_hit", lq_hit, 1);
      fill_ack = 1;
      cyc(); idle();
      #1;
      chk("cnt_after_fill", pending_cnt, 0);
      chk("fill_en_after_fill", fill_en, 0);

      // PUT_M is acked but not recorded; its data return is a protocol error.
      issue(PUT_M, 20'h70, 6'd7, 32'h0, 4'd7);
      #1 chk("ack_putm", iss_ack, 1);
      cyc(); idle();
      #1 chk("cnt_after_putm", pending_cnt, 0);
      mem_tag = 4'd7; mem_data = 32'h1;
      cyc(); idle();
      #1 chk("err_putm_data", err, 1);
      do_reset();

      // IDs 9 and 2: data for 9 first, then 2, drained in that order.
      issue(GET_S, 20'h99, 6'd9, 32'h0, 4'd9); cyc();
      issue(GET_S, 20'h22, 6'd2, 32'h0, 4'd2); cyc(); idle();
      mem_tag = 4'd9; mem_data = 32'h9999; cyc();
      mem_tag = 4'd2; mem_data = 32'h2222; fill_ack = 1;
      #1 chk("drain_first", fill_tag, 20'h99);
      cyc();
      mem_tag = 0;
      #1 chk("drain_second", fill_tag, 20'h22);
      cyc(); idle();
      #1;
      chk("drain_done", fill_en, 0);
      chk("drain_no_err", err, 0);

      // GET_M with store data; probe while ready.
      issue(GET_M, 20'h44, 6'd1, 32'hFF, 4'd4); cyc(); idle();
      mem_tag = 4'd4; mem_data = 32'h1234_5678; cyc(); idle();
      lq_tag = 20'h44; lq_idx = 6'd1;
      #1;
      chk("getm_st_data", fill_st_data, 32'hFF);
      chk("getm_msg", fill_msg, GET_M);
      chk("getm_probe_hit", lq_hit, 1);
      chk("getm_probe_data", lq_hit_data, 32'h1234_5678);
      fill_ack = 1; cyc(); idle();

      // Duplicate record on ID 3 keeps the first fields; reset clears all.
      lq_tag = 20'h33; lq_idx = 6'd2;
      issue(GET_S, 20'h33, 6'd2, 32'h0, 4'd3); cyc();
      issue(GET_M, 20'h3F, 6'd5, 32'hAB, 4'd3); cyc(); idle();
      #1;
      chk("dup_err", err, 1);
      chk("dup_probe_first", lq_pending, 1);
      chk("dup_cnt", pending_cnt, 1);
      do_reset();
      #1;
      chk("midrst_cnt", pending_cnt, 0);
      chk("midrst_err", err, 0);
      chk("midrst_probe", lq_pending, 0);

      // Randomized traffic, mostly legal, with rare protocol violations and resets.
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 499) == 0);
         iss_en   = ($urandom_range(0, 3) != 0);
         iss_msg  = message_t'($urandom_range(0, 3));
         iss_tag  = 20'($urandom_range(0, 3));
         iss_idx  = 6'($urandom_range(0, 3));
         iss_data = $urandom;
         iss_flag = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 99);
         mem_rsp  = (r < 50) ? 4'(pick_state(0)) : (r < 52) ? 4'($urandom_range(1, 15)) : 4'd0;
         r = $urandom_range(0, 99);
         mem_tag  = (r < 45) ? 4'(pick_state(1)) : (r < 47) ? 4'($urandom_range(1, 15)) : 4'd0;
         mem_data = $urandom;
         fill_ack = (model_fill_sel() >= 0 && $urandom_range(0, 1) == 1) ||
                    ($urandom_range(0, 199) == 0);
         lq_tag   = 20'($urandom_range(0, 3));
         lq_idx   = 6'($urandom_range(0, 3));
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mshr_rsp.md
# mshr_rsp

Response-side miss tracker for the non-blocking D-cache controller. It pairs with the issue queue: it acknowledges a head-of-queue request once memory accepts it and returns a transaction ID, then parks the request in a table indexed by that ID. When memory returns data for the ID, the entry becomes ready and is drained to the cache fill port. It also answers load-queue probes so a load does not allocate a duplicate miss.

## Interface
Parameters:
- TXN_NUM, 16: table entries, one per memory transaction ID; ID 0 is the "no response" code and entry 0 is never used.
- TXN_W, 4: log2(TXN_NUM).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- iss_en_i  in  1  issue-side request valid
- iss_tag_i  in  `DCACHE_TAG_W  request tag
- iss_idx_i  in  `DCACHE_IDX_W  request index
- iss_data_i  in  `DCACHE_WORD_IN_BITS  store data carried with GET_M
- iss_message_i  in  message_t  NONE/GET_S/GET_M/PUT_M
- iss_stq_c_flag_i  in  1  store-commit flag
- iss_ack_o  out  1  request accepted by memory; the issue queue pops its head
- mem_rsp_i  in  TXN_W  nonzero = request accepted with this ID
- mem_tag_i  in  TXN_W  nonzero = data returning for this ID
- mem_data_i  in  `DCACHE_WORD_IN_BITS  returned block
- fill_en_o  out  1  ready entry presented
- fill_tag_o, fill_idx_o, fill_message_o, fill_stq_c_flag_o  out  —  copies of the stored request fields
- fill_data_o  out  `DCACHE_WORD_IN_BITS  memory data
- fill_st_data_o  out  `DCACHE_WORD_IN_BITS  stored store data
- fill_ack_i  in  1  cache consumed the fill
- lq_tag_i, lq_idx_i  in  —  load probe address
- lq_pending_o  out  1  probe matches a WAIT entry
- lq_hit_o  out  1  probe matches a RDY entry
- lq_hit_data_o  out  `DCACHE_WORD_IN_BITS  that entry's memory data
- pending_cnt_o  out  TXN_W  number of non-FREE entries
- err_o  out  1  sticky protocol error

## Operation
- Each entry has a 2-bit state: FREE, WAIT, RDY.
- Ack rule: iss_ack_o = iss_en_i && mem_rsp_i != 0. This is combinational.
- Recording on ack:
  - For GET_S or GET_M, entry[mem_rsp_i] changes FREE→WAIT and latches tag, idx, data, message and stq flag.
  - PUT_M and NONE are acked but not recorded, because writebacks return no data.
- Data return: when mem_tag_i != 0, entry[mem_tag_i] changes WAIT→RDY and latches mem_data_i.
- Drain:
  - The lowest-indexed RDY entry drives the fill_* outputs.
  - fill_ack_i changes that entry RDY→FREE and clears its fields to 0/NONE.
- Probe:
  - Compare lq_tag_i/lq_idx_i against all non-FREE entries.
  - A WAIT match asserts lq_pending_o; a RDY match asserts lq_hit_o and returns its data.
  - If several entries match, the lowest index wins.
- Errors: err_o sets and stays set until rst in these cases:
  - a recording ack targets a non-FREE entry;
  - data arrives for an entry that is not WAIT;
  - fill_ack_i arrives while fill_en_o is 0.
- Error handling: the offending event is otherwise ignored, so the entry state is unchanged.

## Timing
- Reset values:
  - all entries FREE, all fields 0, message NONE;
  - outputs fill_en_o=0, lq_*=0, pending_cnt_o=0, err_o=0;
  - iss_ack_o follows its inputs.
- Ack to WAIT: visible in state/pending_cnt_o one cycle after the ack edge.
- Data to fill: fill_en_o is asserted the cycle after the mem_tag_i edge, so load-to-use latency from memory is 1 cycle.
- Drain pacing:
  - fill_* outputs are combinational from registered state.
  - After fill_ack_i, the next RDY entry is presented on the following cycle, giving a drain rate of one per cycle.
- Simultaneous events in one cycle (record, data return and drain on distinct entries) all take effect.
- Same-entry conflicts:
  - record and data to the same ID in one cycle is an error; data is ignored and the record proceeds only if the entry was FREE;
  - data return and fill_ack_i on the same entry cannot occur, since the entry must already be RDY.
- Full: with all 15 entries non-FREE, memory cannot legally issue an ID. A duplicate ID is flagged via err_o.
- pending_cnt_o: registered, range 0..15, and consistent with the state vector every cycle.
- rst mid-operation drops all entries, and any in-flight memory data after reset is flagged as an error.

## Structure
- Shared dcache package holds message_t, the entry-state enum {FREE, WAIT, RDY}, and the `DCACHE_*`/`MSHR_*` widths.
- Sub-module: mshr_rsp_prio_enc, a parameterised lowest-index priority encoder. It is used by both the drain select and the probe-match select.

## Test plan
- After rst, check all outputs are 0. Issue GET_S tag 0x12 idx 3 with mem_rsp_i=5 → iss_ack_o=1, next cycle pending_cnt_o=1 and lq_pending_o=1 for that probe.
- mem_tag_i=5 with data 0xDEAD_BEEF → next cycle fill_en_o=1 with fill_data_o 0xDEADBEEF and tag 0x12. Assert fill_ack_i → pending_cnt_o=0 and fill_en_o=0.
- PUT_M with mem_rsp_i=7 → iss_ack_o=1, pending_cnt_o stays 0, and a later mem_tag_i=7 sets err_o.
- Record IDs 9 and 2, return data for 9 then 2 on consecutive cycles with fill_ack_i held 1 → fills drain in order ID 9 then ID 2.
- Record GET_M at ID 4 with store data 0xFF → fill_st_data_o=0xFF and fill_message_o=GET_M. A probe while RDY gives lq_hit_o=1 with the memory data.
- Record ID 3 twice without a fill → err_o=1 and the first entry's fields are unchanged. Assert rst mid-flight → all entries FREE and err_o=0.
